pool2_ifm_reader: RTL and testbench

//  Producer side of the Pool2 datapath interface. Reads IFM maps from synchronous-read RAM and streams horizontal

---
 rtl/pool2_reader_pkg.sv | 46 ++++
 rtl/pool2_addr_gen.sv | 76 +++++++
 rtl/pool2_ifm_reader.sv | 143 ++++++++++++++
 tb/tb_pool2_ifm_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool2_reader_pkg.sv
// Shared types and sizing helpers for the Pool2 IFM reader.
// FSM encoding, default-derived sizes and width functions.
package pool2_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic int size_next(
    input int size,
    input int kern
  );
    return (size - kern) / 2 + 1;
  endfunction

  function automatic int num_passes(
    input int depth,
    input int units
  );
    return (depth + units - 1) / units;
  endfunction

  function automatic int addr_w(input int size);
    return $clog2(size * size);
  endfunction

  function automatic int pass_w(input int passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

  localparam int DEF_IFM_SIZE  = 14;
  localparam int DEF_IFM_DEPTH = 3;
  localparam int DEF_KERNAL    = 2;
  localparam int DEF_UNITS     = 3;

  localparam int IFM_SIZE_NEXT =
    size_next(DEF_IFM_SIZE, DEF_KERNAL);
  localparam int NUM_PASSES =
    num_passes(DEF_IFM_DEPTH, DEF_UNITS);
  localparam int PAIRS_PER_PASS =
    2 * IFM_SIZE_NEXT * IFM_SIZE_NEXT;

endpackage

// File: rtl/pool2_addr_gen.sv
// Pair address generator: column/row/pass counters.
// Ports: clr/adv in; addr_a/b, pass, row_odd, last_pair out.
module pool2_addr_gen
  import pool2_reader_pkg::*;
#(
  parameter int IFM_SIZE    = 14,
  parameter int KERNAL_SIZE = 2,
  parameter int PASSES      = 1,
  parameter int AW          = 8,
  parameter int PW          = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          adv,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [PW-1:0] pass,
  output logic          row_odd,
  output logic          last_pair
);

  localparam int SN = size_next(IFM_SIZE, KERNAL_SIZE);
  localparam int RW = $clog2(2 * SN + 1);

  localparam logic [AW-1:0] COL_LAST  = AW'(2 * (SN - 1));
  localparam logic [AW-1:0] ROW_STEP  = AW'(IFM_SIZE);
  localparam logic [RW-1:0] ROW_LAST  = RW'(2 * SN - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(PASSES - 1);

  // col holds 2*j; base holds row*IFM_SIZE, kept by
  // accumulation so no multiplier is needed.
  logic [AW-1:0] col;
  logic [AW-1:0] base;
  logic [RW-1:0] row;
  logic          last_col;
  logic          last_row;
  logic          last_pass;

  assign last_col  = (col == COL_LAST);
  assign last_row  = (row == ROW_LAST);
  assign last_pass = (pass == PASS_LAST);
  assign last_pair = last_col & last_row & last_pass;
  assign row_odd   = row[0];
  assign addr_a    = base + col;
  assign addr_b    = addr_a + AW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col  <= '0;
      base <= '0;
      row  <= '0;
      pass <= '0;
    end else if (clr) begin
      col  <= '0;
      base <= '0;
      row  <= '0;
      pass <= '0;
    end else if (adv) begin
      if (!last_col) begin
        col <= col + AW'(2);
      end else begin
        col <= '0;
        if (!last_row) begin
          row  <= row + RW'(1);
          base <= base + ROW_STEP;
        end else begin
          row  <= '0;
          base <= '0;
          pass <= last_pass ? '0 : pass + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pool2_ifm_reader.sv
// Pool2 IFM reader: streams column pairs to three pool units.
// Ports: start/hold in, RAM read out, data/enables out, busy/done.
// Option POOL2_READER_PERF_EN adds stall_count output.
module pool2_ifm_reader
  import pool2_reader_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int IFM_SIZE        = 14,
  parameter int IFM_DEPTH       = 3,
  parameter int KERNAL_SIZE     = 2,
  parameter int NUMBER_OF_UNITS = 3,
  localparam int ADDRESS_SIZE_IFM = addr_w(IFM_SIZE),
  localparam int NUM_PASSES =
    num_passes(IFM_DEPTH, NUMBER_OF_UNITS),
  localparam int PASS_W = pass_w(NUM_PASSES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  output logic                        rd_en,
  output logic [ADDRESS_SIZE_IFM-1:0] rd_addr_A,
  output logic [ADDRESS_SIZE_IFM-1:0] rd_addr_B,
  output logic [PASS_W-1:0]           map_sel,
  input  logic [DATA_WIDTH-1:0]       ram_data_A_unit1,
  input  logic [DATA_WIDTH-1:0]       ram_data_B_unit1,
  input  logic [DATA_WIDTH-1:0]       ram_data_A_unit2,
  input  logic [DATA_WIDTH-1:0]       ram_data_B_unit2,
  input  logic [DATA_WIDTH-1:0]       ram_data_A_unit3,
  input  logic [DATA_WIDTH-1:0]       ram_data_B_unit3,
  output logic [DATA_WIDTH-1:0]       data_in_A_unit1,
  output logic [DATA_WIDTH-1:0]       data_in_B_unit1,
  output logic [DATA_WIDTH-1:0]       data_in_A_unit2,
  output logic [DATA_WIDTH-1:0]       data_in_B_unit2,
  output logic [DATA_WIDTH-1:0]       data_in_A_unit3,
  output logic [DATA_WIDTH-1:0]       data_in_B_unit3,
  output logic                        fifo_enable,
  output logic                        pool_enable,
  output logic                        busy,
  output logic                        done
`ifdef POOL2_READER_PERF_EN
  ,
  output logic [31:0]                 stall_count
`endif
);

  localparam int AW = ADDRESS_SIZE_IFM;

  state_t          state;
  logic            in_read;
  logic            issue;
  logic            start_ok;
  logic            last_pair;
  logic            row_odd;
  logic [AW-1:0]   addr_a;
  logic [AW-1:0]   addr_b;

  assign in_read  = (state == ST_READ);
  assign issue    = in_read & ~hold;
  assign start_ok = (state == ST_IDLE) & start;

  pool2_addr_gen #(
    .IFM_SIZE    (IFM_SIZE),
    .KERNAL_SIZE (KERNAL_SIZE),
    .PASSES      (NUM_PASSES),
    .AW          (AW),
    .PW          (PASS_W)
  ) u_addr (
    .clk       (clk),
    .reset     (reset),
    .clr       (start_ok),
    .adv       (issue),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .pass      (map_sel),
    .row_odd   (row_odd),
    .last_pair (last_pair)
  );

  // Addresses are only meaningful while reading; park at 0.
  assign rd_en     = issue;
  assign rd_addr_A = in_read ? addr_a : '0;
  assign rd_addr_B = in_read ? addr_b : '0;

  assign data_in_A_unit1 = ram_data_A_unit1;
  assign data_in_B_unit1 = ram_data_B_unit1;
  assign data_in_A_unit2 = ram_data_A_unit2;
  assign data_in_B_unit2 = ram_data_B_unit2;
  assign data_in_A_unit3 = ram_data_A_unit3;
  assign data_in_B_unit3 = ram_data_B_unit3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      fifo_enable <= 1'b0;
      pool_enable <= 1'b0;
    end else begin
      // Enables track the RAM's one-cycle read latency.
      fifo_enable <= issue;
      pool_enable <= issue & row_odd;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
          end
        end
        ST_READ: begin
          if (issue && last_pair) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef POOL2_READER_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (start_ok) begin
      stall_count <= '0;
    end else if (in_read && hold && stall_count != '1) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pool2_ifm_reader.sv
// Self-checking bench for pool2_ifm_reader (two-pass config).
// Reference model derives pair order from plain arithmetic.
`timescale 1ns/1ps
module tb_pool2_ifm_reader;

  localparam int DW    = 32;
  localparam int SZ    = 14;
  localparam int DEPTH = 5;
  localparam int UNITS = 3;
  localparam int K     = 2;
  localparam int SN    = (SZ - K) / 2 + 1;
  localparam int PPP   = 2 * SN * SN;
  localparam int NP    = (DEPTH + UNITS - 1) / UNITS;
  localparam int TOTAL = PPP * NP;
  localparam int AW    = $clog2(SZ * SZ);
  localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic hold;
  logic rd_en;
  logic fifo_enable;
  logic pool_enable;
  logic busy;
  logic done;
  logic [AW-1:0] rd_addr_A;
  logic [AW-1:0] rd_addr_B;
  logic [PW-1:0] map_sel;
  logic [DW-1:0] ram_a [3];
  logic [DW-1:0] ram_b [3];
  logic [DW-1:0] din_a [3];
  logic [DW-1:0] din_b [3];
`ifdef POOL2_READER_PERF_EN
  logic [31:0] stall_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit m_busy;
  bit m_read;
  bit m_pend;
  int m_iss;
  int m_pidx;
  int m_tail;
  int unsigned m_stall;
  int o_fifo;
  int o_pool;
  int o_done;

  always #5 clk = ~clk;

  pool2_ifm_reader #(
    .DATA_WIDTH      (DW),
    .IFM_SIZE        (SZ),
    .IFM_DEPTH       (DEPTH),
    .KERNAL_SIZE     (K),
    .NUMBER_OF_UNITS (UNITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .hold             (hold),
    .rd_en            (rd_en),
    .rd_addr_A        (rd_addr_A),
    .rd_addr_B        (rd_addr_B),
    .map_sel          (map_sel),
    .ram_data_A_unit1 (ram_a[0]),
    .ram_data_B_unit1 (ram_b[0]),
    .ram_data_A_unit2 (ram_a[1]),
    .ram_data_B_unit2 (ram_b[1]),
    .ram_data_A_unit3 (ram_a[2]),
    .ram_data_B_unit3 (ram_b[2]),
    .data_in_A_unit1  (din_a[0]),
    .data_in_B_unit1  (din_b[0]),
    .data_in_A_unit2  (din_a[1]),
    .data_in_B_unit2  (din_b[1]),
    .data_in_A_unit3  (din_a[2]),
    .data_in_B_unit3  (din_b[2]),
    .fifo_enable      (fifo_enable),
    .pool_enable      (pool_enable),
    .busy             (busy),
    .done             (done)
`ifdef POOL2_READER_PERF_EN
    ,
    .stall_count      (stall_count)
`endif
  );

  function automatic logic [31:0] word(
    input int unit,
    input int p,
    input int a
  );
    return 32'((unit + 1) * 65536 + p * 256 + a);
  endfunction

  // RAM banks return a tagged copy of the address read.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int n = 0; n < 3; n++) begin
        ram_a[n] <= word(n, int'(map_sel), int'(rd_addr_A));
        ram_b[n] <= word(n, int'(map_sel), int'(rd_addr_B));
      end
    end
  end

  function automatic int pass_of(input int idx);
    return idx / PPP;
  endfunction

  function automatic int row_of(input int idx);
    return (idx % PPP) / SN;
  endfunction

  function automatic int addr_of(input int idx);
    return row_of(idx) * SZ + 2 * (idx % SN);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_busy  = 1'b0;
    m_read  = 1'b0;
    m_pend  = 1'b0;
    m_iss   = 0;
    m_pidx  = 0;
    m_tail  = 0;
    m_stall = 0;
  endtask

  task automatic rst_checks();
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_fifo", 32'(fifo_enable), 32'd0);
    chk("rst_pool", 32'(pool_enable), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_a", 32'(rd_addr_A), 32'd0);
    chk("rst_addr_b", 32'(rd_addr_B), 32'd0);
    chk("rst_map_sel", 32'(map_sel), 32'd0);
`ifdef POOL2_READER_PERF_EN
    chk("rst_stall", stall_count, 32'd0);
`endif
  endtask

  // One clock: check outputs mid-cycle, then advance the model.
  task automatic cyc();
    bit e_rden;
    bit old_busy;
    int p;
    e_rden   = m_read && !hold;
    old_busy = m_busy;
    @(negedge clk);
    chk("rd_en", 32'(rd_en), 32'(e_rden));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_tail == 2));
    chk("fifo_enable", 32'(fifo_enable), 32'(m_pend));
    chk("pool_enable", 32'(pool_enable),
        32'(m_pend && (row_of(m_pidx) % 2 == 1)));
    if (m_read) begin
      chk("rd_addr_A", 32'(rd_addr_A), 32'(addr_of(m_iss)));
      chk("rd_addr_B", 32'(rd_addr_B), 32'(addr_of(m_iss) + 1));
      chk("map_sel", 32'(map_sel), 32'(pass_of(m_iss)));
    end else begin
      chk("idle_addr_A", 32'(rd_addr_A), 32'd0);
      chk("idle_addr_B", 32'(rd_addr_B), 32'd0);
      chk("idle_map_sel", 32'(map_sel), 32'd0);
    end
    if (m_pend) begin
      p = pass_of(m_pidx);
      for (int n = 0; n < 3; n++) begin
        chk("data_in_A", din_a[n], word(n, p, addr_of(m_pidx)));
        chk("data_in_B", din_b[n], word(n, p, addr_of(m_pidx) + 1));
      end
    end
`ifdef POOL2_READER_PERF_EN
    chk("stall_count", stall_count, m_stall);
`endif
    if (fifo_enable === 1'b1) o_fifo++;
    if (pool_enable === 1'b1) o_pool++;
    if (done === 1'b1) o_done++;

    if (m_read && hold && m_stall != 32'hFFFF_FFFF) m_stall++;
    m_pend = e_rden;
    m_pidx = m_iss;
    m_tail = (m_tail == 1) ? 2 : 0;
    if (e_rden) begin
      m_iss++;
      if (m_iss == TOTAL) begin
        m_read = 1'b0;
        m_tail = 1;
      end
    end
    if (old_busy && m_tail == 0 && !m_read) m_busy = 1'b0;
    if (start && !old_busy) begin
      m_busy  = 1'b1;
      m_read  = 1'b1;
      m_iss   = 0;
      m_stall = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    rst_checks();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic frame(
    input bit rnd,
    input int hold_at,
    input int restart_at,
    input int rst_at
  );
    int c;
    int hcnt;
    o_fifo = 0;
    o_pool = 0;
    o_done = 0;
    hold   = 1'b0;
    start  = 1'b1;
    cyc();
    start = 1'b0;
    c     = 0;
    hcnt  = 0;
    while (m_busy && c < LIMIT) begin
      hold  = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      start = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
      if (m_read && m_iss == hold_at && hcnt < 3) begin
        hold = 1'b1;
        hcnt++;
      end
      if (c == restart_at) start = 1'b1;
      if (m_read && m_iss == rst_at) begin
        hold  = 1'b0;
        start = 1'b0;
        do_reset();
        return;
      end
      cyc();
      c++;
    end
    hold  = 1'b0;
    start = 1'b0;
    chk("frame_timeout", 32'(c < LIMIT), 32'd1);
    chk("fifo_pulses", o_fifo, TOTAL);
    chk("pool_pulses", o_pool, TOTAL / 2);
    chk("done_pulses", o_done, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    model_clear();
    #1;
    reset = 1'b0;
    #10;
    rst_checks();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) cyc();
    hold = 1'b1;
    repeat (3) cyc();
    hold = 1'b0;

    frame(1'b0, 3, 10, -1);
    repeat (2) cyc();
    frame(1'b1, -1, -1, -1);
    frame(1'b1, -1, -1, 40);
    repeat (2) cyc();
    frame(1'b1, -1, 25, -1);
    hold = 1'b1;
    repeat (3) cyc();
    hold = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
